// File: rtl/mp_add_pkg.sv
// Shared types and sizing for the multi-precision add sequencer.
package mp_add_pkg;

  localparam int DEF_WORD_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int cnt_w(input int max_words);
    return (max_words > 2) ? $clog2(max_words) : 1;
  endfunction

endpackage

// File: rtl/mp_add_seq_word_adder.sv
// Combinational WORD_W-bit adder with carry in/out.
module word_adder #(
  parameter int WORD_W = 16
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};

endmodule

// File: rtl/mp_add_seq.sv
// Word-serial multi-precision adder, LSW first, registered carry between words.
// Optional subtract mode (A-B) when MP_ADD_SEQ_SUB_EN is defined.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int MAX_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic              in_cin,
  input  logic              in_last,
`ifdef MP_ADD_SEQ_SUB_EN
  input  logic              in_sub,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_sum,
  output logic              out_last,
  output logic              out_cout,
  output logic              err
);

  localparam int CNT_W = cnt_w(MAX_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WORDS - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  count_q;
  logic              carry_q;
  logic              out_valid_q;
  logic [WORD_W-1:0] out_sum_q;
  logic              out_last_q;
  logic              out_cout_q;
  logic              err_q;

  logic              xfer;
  logic              overlen;
  logic              last_d;
  logic [WORD_W-1:0] b_eff;
  logic              carry_src;
  logic [WORD_W-1:0] sum_d;
  logic              cout_d;

  assign in_ready = !out_valid_q || out_ready;
  assign xfer     = in_valid && in_ready;
  assign overlen  = (count_q == CNT_LAST);
  assign last_d   = in_last || overlen;

`ifdef MP_ADD_SEQ_SUB_EN
  logic sub_q;
  logic sub_eff;

  // Subtract mode is chosen on the first word and held for the operand.
  assign sub_eff   = (state_q == IDLE) ? in_sub : sub_q;
  assign b_eff     = sub_eff ? ~in_b : in_b;
  assign carry_src = (state_q == IDLE) ? (in_sub | in_cin) : carry_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else if (xfer && state_q == IDLE) begin
      sub_q <= in_sub;
    end
  end
`else
  assign b_eff     = in_b;
  assign carry_src = (state_q == IDLE) ? in_cin : carry_q;
`endif

  word_adder #(.WORD_W(WORD_W)) u_add (
    .a    (in_a),
    .b    (b_eff),
    .cin  (carry_src),
    .sum  (sum_d),
    .cout (cout_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      err_q       <= 1'b0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_sum_q   <= sum_d;
      out_cout_q  <= cout_d;
      out_last_q  <= last_d;
      carry_q     <= cout_d;
      if (overlen && !in_last) begin
        err_q <= 1'b1;
      end
      if (last_d) begin
        state_q <= IDLE;
        count_q <= '0;
      end else begin
        state_q <= RUN;
        count_q <= count_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign out_cout  = out_cout_q;
  assign err       = err_q;

endmodule
